// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
// Contents: fetch_state_e (FSM states), line geometry constants, line_align().
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StBackoff,
    StFault
  } fetch_state_e;

  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned FQ_W       = 160;

  // Clear the byte offset so a PC points at the start of its 16 B line.
  function automatic logic [31:0] line_align(input logic [31:0] pc);
    return {pc[31:4], 4'h0};
  endfunction

endpackage

// File: rtl/fetch_backoff_timer.sv
// Back-off down-counter used between a miss and the retry of the same line.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - force count to 0 (redirect)
//   load      - load MISS_LAT-1 (entering back-off)
//   dec       - decrement while non-zero
//   zero      - count is 0
module fetch_backoff_timer #(
  parameter int unsigned MISS_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned W = $clog2(MISS_LAT + 1);
  localparam logic [W-1:0] LoadVal = W'(MISS_LAT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LoadVal;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, reads 128-bit lines from a
// combinational i_cache, pushes valid lines to the fetch queue, backs off and
// retries on invalid lines, faults after MAX_RETRY misses, and obeys redirects.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating perf counters
//   perf_lines / perf_miss / perf_stall.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   fetch_en                     - allow fetching
//   redirect_valid, redirect_pc  - back-end redirect pulse and target
//   ic_pc, ic_rd_en, ic_abort    - i_cache request side
//   ic_dout, ic_dout_valid       - i_cache line and its validity
//   fq_full, fq_wr_en, fq_din    - fetch queue push interface ({pc, line})
//   fetch_fault                  - sticky retry-exhausted flag
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MISS_LAT  = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       ic_pc,
  output logic              ic_rd_en,
  output logic              ic_abort,
  input  logic [LINE_W-1:0] ic_dout,
  input  logic              ic_dout_valid,
  input  logic              fq_full,
  output logic              fq_wr_en,
  output logic [FQ_W-1:0]   fq_din,
  output logic              fetch_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_lines,
  output logic [31:0]       perf_miss,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RetryLim = RW'(MAX_RETRY);

  fetch_state_e   state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           fault_q, fault_d;
  logic           rd_en, push;
  logic           tmr_clear, tmr_load, tmr_dec, tmr_zero;

  fetch_backoff_timer #(
    .MISS_LAT (MISS_LAT)
  ) u_backoff (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retry_d   = retry_q;
    fault_d   = fault_q;
    rd_en     = 1'b0;
    push      = 1'b0;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fetch_en) state_d = StFetch;
      end
      StFetch: begin
        rd_en = 1'b1;
        if (ic_dout_valid) begin
          // A full queue is a stall, not a miss: PC and retry count hold.
          if (!fq_full) begin
            push    = 1'b1;
            pc_d    = pc_q + 32'(LINE_BYTES);
            retry_d = '0;
          end
          if (!fetch_en) state_d = StIdle;
        end else begin
          retry_d = retry_q + 1'b1;
          if (retry_d == RetryLim) begin
            state_d = StFault;
            fault_d = 1'b1;
          end else begin
            state_d  = StBackoff;
            tmr_load = 1'b1;
          end
        end
      end
      StBackoff: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_d = fetch_en ? StFetch : StIdle;
      end
      StFault: begin
        // Only a redirect or reset leaves this state.
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides every state decision; any line read this cycle is dropped.
    if (redirect_valid) begin
      push      = 1'b0;
      tmr_load  = 1'b0;
      tmr_clear = 1'b1;
      pc_d      = line_align(redirect_pc);
      retry_d   = '0;
      fault_d   = 1'b0;
      state_d   = fetch_en ? StFetch : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= line_align(RESET_PC);
      retry_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
    end
  end

  // Outputs are forced quiet while rst is high, since state only resets at the edge.
  assign ic_pc       = pc_q;
  assign ic_rd_en    = rd_en & ~rst;
  assign ic_abort    = redirect_valid & ~rst;
  assign fq_wr_en    = push & ~rst;
  assign fq_din      = rst ? '0 : {pc_q, ic_dout};
  assign fetch_fault = fault_q & ~rst;

`ifdef FETCH_PERF_CNT_EN
  logic        miss_ev, stall_ev;
  logic [31:0] lines_q, miss_q, stall_q;

  assign miss_ev  = (state_q == StFetch) & ~ic_dout_valid & ~redirect_valid;
  assign stall_ev = (state_q == StFetch) & ic_dout_valid & fq_full & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      lines_q <= '0;
      miss_q  <= '0;
      stall_q <= '0;
    end else begin
      if (push && (lines_q != '1))     lines_q <= lines_q + 1'b1;
      if (miss_ev && (miss_q != '1))   miss_q  <= miss_q + 1'b1;
      if (stall_ev && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign perf_lines = rst ? '0 : lines_q;
  assign perf_miss  = rst ? '0 : miss_q;
  assign perf_stall = rst ? '0 : stall_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl (default parameters: RESET_PC=0, MISS_LAT=4, MAX_RETRY=3).
// Directed per-cycle stimulus; expected pushes go into a queue that a separate
// monitor pops whenever fq_wr_en is seen.
module tb_fetch_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_en;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic [31:0]  ic_pc;
  logic         ic_rd_en;
  logic         ic_abort;
  logic [127:0] ic_dout;
  logic         ic_dout_valid;
  logic         fq_full;
  logic         fq_wr_en;
  logic [159:0] fq_din;
  logic         fetch_fault;
  logic         inv;

  int n_checks = 0;
  int n_fail   = 0;
  logic [159:0] exp_q[$];

  always #5 clk = ~clk;

  // Cache model: each word of a line carries its own address.
  function automatic logic [127:0] line_of(input logic [31:0] pc);
    return {pc + 32'hC, pc + 32'h8, pc + 32'h4, pc};
  endfunction

  assign ic_dout       = line_of(ic_pc);
  assign ic_dout_valid = ic_rd_en & ~inv;

  fetch_ctrl u_dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ic_pc          (ic_pc),
    .ic_rd_en       (ic_rd_en),
    .ic_abort       (ic_abort),
    .ic_dout        (ic_dout),
    .ic_dout_valid  (ic_dout_valid),
    .fq_full        (fq_full),
    .fq_wr_en       (fq_wr_en),
    .fq_din         (fq_din),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_q.push_back({pc, line_of(pc)});
  endtask

  // Check one cycle's outputs at the falling edge, then move to just after the next rising edge.
  task automatic step(input string name, input logic rd, input logic wr, input logic ab,
                      input logic flt, input logic [31:0] pc);
    @(negedge clk);
    chk({name, ".ic_rd_en"},    160'(ic_rd_en),    160'(rd));
    chk({name, ".fq_wr_en"},    160'(fq_wr_en),    160'(wr));
    chk({name, ".ic_abort"},    160'(ic_abort),    160'(ab));
    chk({name, ".fetch_fault"}, 160'(fetch_fault), 160'(flt));
    chk({name, ".ic_pc"},       160'(ic_pc),       160'(pc));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  initial begin
    logic [159:0] e;
    forever begin
      @(negedge clk);
      if (fq_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_push: got %h expected no push", fq_din);
        end else begin
          e = exp_q.pop_front();
          chk("push_data", fq_din, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    inv = 1'b0; fq_full = 1'b0;
    @(posedge clk);
    #1;
    step("reset", 0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    step("idle", 0, 0, 0, 0, 32'h0);

    // Back-to-back pushes from reset PC.
    for (int i = 0; i < 4; i++) begin
      exp_push(32'(i * 16));
      step("stream", 1, 1, 0, 0, 32'(i * 16));
    end

    // Single miss at 0x40: four idle back-off cycles, then retry succeeds.
    inv = 1'b1;
    step("miss_40", 1, 0, 0, 0, 32'h40);
    inv = 1'b0;
    repeat (4) step("backoff_40", 0, 0, 0, 0, 32'h40);
    exp_push(32'h40);
    step("retry_40", 1, 1, 0, 0, 32'h40);
    for (int i = 5; i < 8; i++) begin
      exp_push(32'(i * 16));
      step("stream2", 1, 1, 0, 0, 32'(i * 16));
    end

    // Queue full at 0x80: stall without back-off, then one push.
    fq_full = 1'b1;
    repeat (5) step("stall_80", 1, 0, 0, 0, 32'h80);
    fq_full = 1'b0;
    exp_push(32'h80);
    step("push_80", 1, 1, 0, 0, 32'h80);

    // Redirect coinciding with a valid line: line dropped, abort raised.
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step("redir_90", 1, 0, 1, 0, 32'h90);
    redirect_valid = 1'b0;
    exp_push(32'h200);
    step("push_200", 1, 1, 0, 0, 32'h200);

    // Three misses at 0x210 -> FAULT.
    inv = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      step("miss_210", 1, 0, 0, 0, 32'h210);
      if (r < 3) repeat (4) step("backoff_210", 0, 0, 0, 0, 32'h210);
    end
    fetch_en = 1'b0;
    step("fault_hold", 0, 0, 0, 1, 32'h210);
    fetch_en = 1'b1;
    repeat (2) step("fault_hold", 0, 0, 0, 1, 32'h210);

    // Redirect out of FAULT with an unaligned target.
    redirect_valid = 1'b1; redirect_pc = 32'h104;
    step("redir_fault", 0, 0, 1, 1, 32'h210);
    redirect_valid = 1'b0; inv = 1'b0;
    exp_push(32'h100);
    step("push_100", 1, 1, 0, 0, 32'h100);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF4;
    step("redir_wrap", 1, 0, 1, 0, 32'h110);
    redirect_valid = 1'b0;
    exp_push(32'hFFFF_FFF0);
    step("push_top", 1, 1, 0, 0, 32'hFFFF_FFF0);
    exp_push(32'h0);
    step("push_wrap", 1, 1, 0, 0, 32'h0);

    // Reset in the middle of back-off.
    inv = 1'b1;
    step("miss_10", 1, 0, 0, 0, 32'h10);
    inv = 1'b0;
    step("backoff_10", 0, 0, 0, 0, 32'h10);
    rst = 1'b1;
    step("rst_backoff", 0, 0, 0, 0, 32'h10);
    rst = 1'b0; fetch_en = 1'b0;
    repeat (2) step("post_rst_idle", 0, 0, 0, 0, 32'h0);

    // Dropping fetch_en in FETCH completes the push, then idles.
    fetch_en = 1'b1;
    step("idle2", 0, 0, 0, 0, 32'h0);
    fetch_en = 1'b0;
    exp_push(32'h0);
    step("last_push", 1, 1, 0, 0, 32'h0);
    step("stopped", 0, 0, 0, 0, 32'h10);

    @(negedge clk);
    chk("scoreboard_empty", 160'(exp_q.size()), 160'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
